// File: rtl/esfa_array_pipelined.sv
// Tagged cell store with a registered lowest-handle reduction tree and a sweep FSM that invalidates all cells.
// Optional macro ESFA_MULTIHIT_EN adds r_multi (two or more cells matched), aligned with r_valid.
module esfa_array_pipelined #(
  parameter  int NUM_CELLS = 8,
  parameter  int IDX_W     = 8,
  parameter  int VAL_W     = 8,
  parameter  int META_W    = 8,
  localparam int HANDLE_W  = $clog2(NUM_CELLS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  output logic                busy,
  input  logic                wr_en,
  input  logic                wr_clear,
  input  logic                wr_is_meta,
  input  logic [HANDLE_W-1:0] wr_handle,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [VAL_W-1:0]    wr_value,
  input  logic [META_W-1:0]   wr_meta,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [IDX_W-1:0]    q_selector,
  output logic                r_valid,
  output logic                r_hit,
  output logic [HANDLE_W-1:0] r_handle,
  output logic [VAL_W-1:0]    r_value,
  output logic [META_W-1:0]   r_meta
`ifdef ESFA_MULTIHIT_EN
  ,
  output logic                r_multi
`endif
);

  localparam int LEVELS = HANDLE_W;

  localparam logic ST_SWEEP = 1'b0;
  localparam logic ST_READY = 1'b1;

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  logic                state_q, state_d;
  logic [HANDLE_W-1:0] ptr_q, ptr_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_SWEEP: begin
        if (ptr_q == HANDLE_W'(NUM_CELLS - 1)) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + HANDLE_W'(1);
        end
      end
      default: begin
        if (flush) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // NOTE: clocked blocks use non-blocking '<=' so every register samples the
  // pre-edge value of every other register, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy    = (state_q == ST_SWEEP);
  assign q_ready = !busy;

  // ---------------------------------------------------------------------------
  // Cell storage
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]     cell_idx_q  [NUM_CELLS];
  logic [VAL_W-1:0]     cell_val_q  [NUM_CELLS];
  logic [META_W-1:0]    cell_meta_q [NUM_CELLS];
  logic [NUM_CELLS-1:0] cell_valid_q;

  // NOTE: the cell array has no reset; the valid bits are cleared by the sweep
  // one cell per cycle, so the payload never needs a reset tree.
  always_ff @(posedge clk) begin
    if (busy) begin
      cell_valid_q[ptr_q] <= 1'b0;
    end else if (wr_en) begin
      if (wr_clear) begin
        cell_valid_q[wr_handle] <= 1'b0;
      end else if (wr_is_meta) begin
        cell_meta_q[wr_handle] <= wr_meta;
      end else begin
        cell_idx_q[wr_handle]   <= wr_index;
        cell_val_q[wr_handle]   <= wr_value;
        cell_meta_q[wr_handle]  <= wr_meta;
        cell_valid_q[wr_handle] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Query pipeline: leaf compare stage, then one registered combine per level
  // ---------------------------------------------------------------------------
  logic              q_accept;
  logic [LEVELS:0]   vld_q;

  assign q_accept = q_valid && !busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LEVELS-1:0], q_accept};
    end
  end

  // Every node payload is zero unless its hit bit is set, so a miss (or a bubble)
  // reaches the outputs as all-zero without a separate output mask.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int NODES = NUM_CELLS >> l;

    logic                hit_q  [NODES];
    logic [HANDLE_W-1:0] hdl_q  [NODES];
    logic [VAL_W-1:0]    val_q  [NODES];
    logic [META_W-1:0]   meta_q [NODES];
`ifdef ESFA_MULTIHIT_EN
    logic                multi_q[NODES];
`endif

    for (genvar n = 0; n < NODES; n++) begin : g_node
      logic                hit_d;
      logic [HANDLE_W-1:0] hdl_d;
      logic [VAL_W-1:0]    val_d;
      logic [META_W-1:0]   meta_d;
`ifdef ESFA_MULTIHIT_EN
      logic                multi_d;
`endif

      if (l == 0) begin : g_leaf
        always_comb begin
          hit_d  = q_accept && cell_valid_q[n] && (cell_idx_q[n] == q_selector);
          hdl_d  = hit_d ? HANDLE_W'(n) : '0;
          val_d  = hit_d ? cell_val_q[n] : '0;
          meta_d = hit_d ? cell_meta_q[n] : '0;
`ifdef ESFA_MULTIHIT_EN
          multi_d = 1'b0;
`endif
        end
      end else begin : g_comb
        // Left child holds the lower handles, so it wins whenever it hit.
        logic lh, rh;
        assign lh = g_lvl[l-1].hit_q[2*n];
        assign rh = g_lvl[l-1].hit_q[2*n+1];

        always_comb begin
          hit_d  = lh | rh;
          hdl_d  = lh ? g_lvl[l-1].hdl_q[2*n]  : g_lvl[l-1].hdl_q[2*n+1];
          val_d  = lh ? g_lvl[l-1].val_q[2*n]  : g_lvl[l-1].val_q[2*n+1];
          meta_d = lh ? g_lvl[l-1].meta_q[2*n] : g_lvl[l-1].meta_q[2*n+1];
`ifdef ESFA_MULTIHIT_EN
          multi_d = (lh & rh) | g_lvl[l-1].multi_q[2*n] | g_lvl[l-1].multi_q[2*n+1];
`endif
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hit_q[n]  <= 1'b0;
          hdl_q[n]  <= '0;
          val_q[n]  <= '0;
          meta_q[n] <= '0;
`ifdef ESFA_MULTIHIT_EN
          multi_q[n] <= 1'b0;
`endif
        end else begin
          hit_q[n]  <= hit_d;
          hdl_q[n]  <= hdl_d;
          val_q[n]  <= val_d;
          meta_q[n] <= meta_d;
`ifdef ESFA_MULTIHIT_EN
          multi_q[n] <= multi_d;
`endif
        end
      end
    end
  end

  assign r_valid  = vld_q[LEVELS];
  assign r_hit    = g_lvl[LEVELS].hit_q[0];
  assign r_handle = g_lvl[LEVELS].hdl_q[0];
  assign r_value  = g_lvl[LEVELS].val_q[0];
  assign r_meta   = g_lvl[LEVELS].meta_q[0];
`ifdef ESFA_MULTIHIT_EN
  assign r_multi  = g_lvl[LEVELS].multi_q[0];
`endif

endmodule

// File: tb/tb_esfa_array_pipelined.sv
// Scoreboard bench for esfa_array_pipelined: a behavioural cell model predicts each accepted query's result.
// Results are popped in order on r_valid; a query driven in cycle c must complete in cycle c+L.
module tb_esfa_array_pipelined;

  localparam int N  = 8;
  localparam int HW = 3;
  localparam int L  = 1 + HW;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          busy;
  logic          wr_en, wr_clear, wr_is_meta;
  logic [HW-1:0] wr_handle;
  logic [7:0]    wr_index, wr_value, wr_meta;
  logic          q_valid, q_ready;
  logic [7:0]    q_selector;
  logic          r_valid, r_hit;
  logic [HW-1:0] r_handle;
  logic [7:0]    r_value, r_meta;
`ifdef ESFA_MULTIHIT_EN
  logic          r_multi;
`endif

  esfa_array_pipelined #(
    .NUM_CELLS(N), .IDX_W(8), .VAL_W(8), .META_W(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .busy       (busy),
    .wr_en      (wr_en),
    .wr_clear   (wr_clear),
    .wr_is_meta (wr_is_meta),
    .wr_handle  (wr_handle),
    .wr_index   (wr_index),
    .wr_value   (wr_value),
    .wr_meta    (wr_meta),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_selector (q_selector),
    .r_valid    (r_valid),
    .r_hit      (r_hit),
    .r_handle   (r_handle),
    .r_value    (r_value),
    .r_meta     (r_meta)
`ifdef ESFA_MULTIHIT_EN
    ,
    .r_multi    (r_multi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          hit;
    logic [HW-1:0] hdl;
    logic [7:0]    val;
    logic [7:0]    meta;
    logic          multi;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic       m_valid [N];
  logic [7:0] m_idx   [N];
  logic [7:0] m_val   [N];
  logic [7:0] m_meta  [N];
  int         busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic exp_t model_lookup(input logic [7:0] sel);
    exp_t e;
    int   cnt;
    e.hit = 1'b0; e.hdl = '0; e.val = '0; e.meta = '0; e.multi = 1'b0; e.cyc = 0;
    cnt = 0;
    for (int h = 0; h < N; h++) begin
      if (m_valid[h] && m_idx[h] == sel) begin
        if (cnt == 0) begin
          e.hit  = 1'b1;
          e.hdl  = HW'(h);
          e.val  = m_val[h];
          e.meta = m_meta[h];
        end
        cnt++;
      end
    end
    e.multi = (cnt >= 2);
    return e;
  endfunction

  // Result monitor: every r_valid cycle pops one prediction; idle cycles must be all-zero.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (r_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_r_valid", 32'(r_valid), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          check("r_hit",    32'(r_hit),    32'(mon_e.hit));
          check("r_handle", 32'(r_handle), 32'(mon_e.hdl));
          check("r_value",  32'(r_value),  32'(mon_e.val));
          check("r_meta",   32'(r_meta),   32'(mon_e.meta));
`ifdef ESFA_MULTIHIT_EN
          check("r_multi",  32'(r_multi),  32'(mon_e.multi));
`endif
          check("latency",  32'(cyc),      32'(mon_e.cyc));
        end
      end else begin
        check("idle_zero", 32'({r_hit, r_handle, r_value, r_meta}), 32'(0));
      end
    end
  end

  // One bus cycle, entered and left on a falling edge. Acceptance is predicted
  // from the bench's own busy counter, then compared against busy/q_ready.
  task automatic drive(input logic fl, input logic we, input logic clr, input logic ism,
                       input logic [HW-1:0] h, input logic [7:0] idx, input logic [7:0] val,
                       input logic [7:0] meta, input logic qv, input logic [7:0] sel);
    logic bz;
    exp_t e;
    bz = (busy_cnt > 0);
    check("busy",    32'(busy),    32'(bz));
    check("q_ready", 32'(q_ready), 32'(!bz));
    flush = fl; wr_en = we; wr_clear = clr; wr_is_meta = ism;
    wr_handle = h; wr_index = idx; wr_value = val; wr_meta = meta;
    q_valid = qv; q_selector = sel;
    if (qv && !bz) begin
      e = model_lookup(sel);
      e.cyc = cyc + L;
      sb.push_back(e);
    end
    if (we && !bz) begin
      if (clr) m_valid[h] = 1'b0;
      else if (ism) m_meta[h] = meta;
      else begin
        m_idx[h] = idx; m_val[h] = val; m_meta[h] = meta; m_valid[h] = 1'b1;
      end
    end
    if (bz) busy_cnt--;
    else if (fl) begin
      busy_cnt = N;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0; q_valid = 1'b0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, 8'h00, 8'h00, 8'h00, 0, 8'h00);
  endtask
  task automatic wr_full(input logic [HW-1:0] h, input logic [7:0] idx, input logic [7:0] val, input logic [7:0] meta);
    drive(0, 1, 0, 0, h, idx, val, meta, 0, 8'h00);
  endtask
  task automatic wr_meta_only(input logic [HW-1:0] h, input logic [7:0] meta);
    drive(0, 1, 0, 1, h, 8'hEE, 8'hEE, meta, 0, 8'h00);
  endtask
  task automatic wr_clr(input logic [HW-1:0] h);
    drive(0, 1, 1, 0, h, 8'hEE, 8'hEE, 8'hEE, 0, 8'h00);
  endtask
  task automatic query(input logic [7:0] sel);
    drive(0, 0, 0, 0, '0, 8'h00, 8'h00, 8'h00, 1, sel);
  endtask

  // Counts busy cycles after reset release while hammering refused writes/queries.
  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    wr_en = 1'b1; wr_handle = '0; wr_index = 8'h00; wr_value = 8'hEE; wr_meta = 8'hEE;
    q_valid = 1'b1; q_selector = 8'h00;
    while (busy === 1'b1 && cnt < 4 * N) begin
      check({tag, "_q_ready"}, 32'(q_ready), 32'(0));
      cnt++;
      @(negedge clk);
    end
    wr_en = 1'b0; q_valid = 1'b0;
    check(tag, 32'(cnt), 32'(N));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] pool [5];
    pool[0] = 8'h10; pool[1] = 8'h2A; pool[2] = 8'h33; pool[3] = 8'h77; pool[4] = 8'h05;

    reset_n = 1'b0;
    flush = 1'b0; wr_en = 1'b0; wr_clear = 1'b0; wr_is_meta = 1'b0;
    wr_handle = '0; wr_index = '0; wr_value = '0; wr_meta = '0;
    q_valid = 1'b0; q_selector = '0;
    busy_cnt = 0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_idx[i] = '0; m_val[i] = '0; m_meta[i] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_busy",    32'(busy),    32'(1));
    check("rst_q_ready", 32'(q_ready), 32'(0));
    check("rst_r_valid", 32'(r_valid), 32'(0));

    // Release, then re-assert reset part-way through the sweep: it must restart from cell 0.
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_sweep_busy", 32'(busy), 32'(1));
    reset_n = 1'b0;
    @(negedge clk);
    check("rerst_busy", 32'(busy), 32'(1));
    reset_n = 1'b1;
    count_busy("reset_busy_len");

    query(8'h00);

    wr_full(3, 8'h2A, 8'h55, 8'hA3);
    query(8'h2A);

    wr_full(1, 8'h10, 8'h11, 8'hB1);
    wr_full(6, 8'h10, 8'h66, 8'hB6);
    query(8'h10);

    query(8'h2A);
    query(8'h77);
    query(8'h10);

    // Same-cycle write and query: the query sees the old contents.
    drive(0, 1, 0, 0, 2, 8'h33, 8'h22, 8'hC2, 1, 8'h33);
    query(8'h33);

    wr_meta_only(3, 8'hC7);
    query(8'h2A);

    wr_clr(6);
    query(8'h10);
    wr_clr(1);
    query(8'h10);
    wr_full(1, 8'h10, 8'h11, 8'hB1);

    // Flush with a query in flight and one in the flush cycle itself.
    query(8'h2A);
    drive(1, 0, 0, 0, '0, 8'h00, 8'h00, 8'h00, 1, 8'h10);
    for (int i = 0; i < N; i++) begin
      drive(1, 1, 0, 0, HW'(i), 8'h2A, 8'h99, 8'h99, 1, 8'h2A);
    end
    query(8'h2A);
    query(8'h10);
    query(8'h33);

    wr_full(3, 8'h2A, 8'h55, 8'hA3);
    wr_meta_only(3, 8'h5C);
    query(8'h2A);

    // Random mix over a small index pool so hits and multi-hits are common.
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 39);
      drive(op == 0, op > 20, op inside {[21:24]}, op inside {[25:28]},
            HW'($urandom_range(0, N - 1)), pool[$urandom_range(0, 4)],
            8'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0), pool[$urandom_range(0, 4)]);
    end

    while (busy_cnt > 0) idle();
    repeat (L + 2) idle();
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
